// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle for the pipelined N:1 selector: source-side payload/valid and
// sink-side result/ready.
interface mux_nto1_pipe_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = 5
) ();
    logic [NUM_IN*N-1:0] din;
    logic [SEL_W-1:0]    sel;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        dout;
    logic                dout_oob;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, dout, dout_oob, out_valid
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, dout, dout_oob, out_valid
    );
endinterface

// File: rtl/mux_nto1_pipe.sv
// Pipelined radix-R N:1 selector with valid/ready flow control, bubble collapsing
// and out-of-range select flagging.
module mux_nto1_pipe #(
    parameter int unsigned N      = 8,
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned RADIX  = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux_nto1_pipe_if.slave  bus
);

    // Number of live lanes left after lvl levels of radix reduction.
    function automatic int unsigned lvl_cnt(input int unsigned lvl);
        int unsigned c;
        c = NUM_IN;
        for (int unsigned i = 0; i < lvl; i++) c = (c + RADIX - 1) / RADIX;
        return c;
    endfunction

    function automatic int unsigned stg_cnt();
        int unsigned c;
        int unsigned n;
        c = NUM_IN;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (c > 1) begin
                c = (c + RADIX - 1) / RADIX;
                n++;
            end
        end
        return n;
    endfunction

    localparam int unsigned LOG_R   = $clog2(RADIX);
    localparam int unsigned NUM_STG = stg_cnt();
    localparam int unsigned SW      = NUM_STG * LOG_R;

    if (NUM_IN < 2) begin : g_chk_num_in
        $error("mux_nto1_pipe: NUM_IN must be at least 2");
    end
    if (SEL_W < $clog2(NUM_IN)) begin : g_chk_sel_w
        $error("mux_nto1_pipe: SEL_W too narrow for NUM_IN");
    end
    if (RADIX < 2 || (RADIX & (RADIX - 1)) != 0) begin : g_chk_radix
        $error("mux_nto1_pipe: RADIX must be a power of 2 and at least 2");
    end

    // Entry clamp: out-of-range selects steer to channel 0 and raise the flag.
    logic          oob_e;
    logic [SW-1:0] sel_e;

    assign oob_e = {1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN);
    assign sel_e = oob_e ? '0 : SW'(bus.sel);

    logic [NUM_STG:0]   en;
    logic [NUM_STG-1:0] v;
    logic [NUM_STG-1:0] oob;

    assign en[NUM_STG] = bus.out_ready;

    for (genvar s = 0; s < NUM_STG; s++) begin : g_stg
        localparam int unsigned IN_CNT  = lvl_cnt(s);
        localparam int unsigned OUT_CNT = lvl_cnt(s + 1);
        localparam int unsigned IN_SW   = (NUM_STG - s) * LOG_R;

        logic [IN_CNT*N-1:0]  in_data;
        logic [IN_SW-1:0]     sel_in;
        logic                 v_in;
        logic                 oob_in;
        logic [LOG_R-1:0]     digit;
        logic [N-1:0]         grp [OUT_CNT][RADIX];
        logic [OUT_CNT*N-1:0] data_d;
        logic [OUT_CNT*N-1:0] data_q;
        logic                 v_q;
        logic                 oob_q;

        if (s == 0) begin : g_first
            assign in_data = bus.din;
            assign sel_in  = sel_e;
            assign v_in    = bus.in_valid;
            assign oob_in  = oob_e;
        end else begin : g_next
            assign in_data = g_stg[s-1].data_q;
            assign sel_in  = g_stg[s-1].g_rem.sel_q;
            assign v_in    = v[s-1];
            assign oob_in  = oob[s-1];
        end

        assign digit = sel_in[LOG_R-1:0];

        // Partial groups pad with zero lanes; the entry clamp keeps them unreachable.
        for (genvar g = 0; g < OUT_CNT; g++) begin : g_grp
            for (genvar r = 0; r < RADIX; r++) begin : g_leg
                if (g * RADIX + r < IN_CNT) begin : g_live
                    assign grp[g][r] = in_data[(g*RADIX+r)*N +: N];
                end else begin : g_tie
                    assign grp[g][r] = '0;
                end
            end
            assign data_d[g*N +: N] = grp[g][digit];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                oob_q  <= 1'b0;
                data_q <= '0;
            end else if (en[s]) begin
                v_q    <= v_in;
                oob_q  <= oob_in;
                data_q <= data_d;
            end
        end

        // Remaining select digits ride along with the data to the next stage.
        if (s + 1 < NUM_STG) begin : g_rem
            logic [IN_SW-LOG_R-1:0] sel_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_q <= '0;
                end else if (en[s]) begin
                    sel_q <= sel_in[IN_SW-1:LOG_R];
                end
            end
        end

        assign v[s]   = v_q;
        assign oob[s] = oob_q;
        assign en[s]  = !v_q || en[s+1];
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v[NUM_STG-1];
    assign bus.dout_oob  = oob[NUM_STG-1];
    assign bus.dout      = g_stg[NUM_STG-1].data_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: a FIFO-with-minimum-latency reference model
// checked every cycle, plus literal expectations on the delivered transfer log.
module tb_mux_nto1_pipe;

    localparam int STG = 2;

    typedef struct {
        logic [7:0] d;
        logic       oob;
        int         t;
        int         oc;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   armed    = 1'b0;

    item_t qa[$];
    item_t qb[$];
    item_t loga[$];
    item_t logb[$];

    always #5 clk = ~clk;

    mux_nto1_pipe_if #(.N(8), .NUM_IN(16), .SEL_W(5)) bus_a ();
    mux_nto1_pipe_if #(.N(8), .NUM_IN(5),  .SEL_W(3)) bus_b ();

    mux_nto1_pipe #(.N(8), .NUM_IN(16), .SEL_W(5), .RADIX(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_nto1_pipe #(.N(8), .NUM_IN(5), .SEL_W(3), .RADIX(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Selected channel, with out-of-range selects delivering channel 0 flagged.
    function automatic item_t ref_a(input logic [127:0] din, input logic [4:0] sel);
        item_t it;
        int    ch;
        it.oob = (int'(sel) >= 16);
        ch     = it.oob ? 0 : int'(sel);
        it.d   = din[ch*8 +: 8];
        it.t   = 0;
        it.oc  = 0;
        return it;
    endfunction

    function automatic item_t ref_b(input logic [39:0] din, input logic [2:0] sel);
        item_t it;
        int    ch;
        it.oob = (int'(sel) >= 5);
        ch     = it.oob ? 0 : int'(sel);
        it.d   = din[ch*8 +: 8];
        it.t   = 0;
        it.oc  = 0;
        return it;
    endfunction

    // The oldest item is never blocked, so it is visible STG cycles after accept.
    logic       a_stall, b_stall;
    logic [8:0] a_prev, b_prev;

    always @(negedge clk) begin : mon
        item_t it;
        if (armed) begin
            chk("a_out_valid", 32'(bus_a.out_valid), 32'(qa.size() > 0 && cyc - qa[0].t >= STG));
            chk("a_in_ready", 32'(bus_a.in_ready), 32'(qa.size() < STG || bus_a.out_ready));
            if (bus_a.out_valid && qa.size() > 0) begin
                chk("a_dout", 32'(bus_a.dout), 32'(qa[0].d));
                chk("a_dout_oob", 32'(bus_a.dout_oob), 32'(qa[0].oob));
            end
            if (a_stall) chk("a_hold", 32'({bus_a.out_valid, bus_a.dout, bus_a.dout_oob}), 32'({1'b1, a_prev}));
            chk("b_out_valid", 32'(bus_b.out_valid), 32'(qb.size() > 0 && cyc - qb[0].t >= STG));
            chk("b_in_ready", 32'(bus_b.in_ready), 32'(qb.size() < STG || bus_b.out_ready));
            if (bus_b.out_valid && qb.size() > 0) begin
                chk("b_dout", 32'(bus_b.dout), 32'(qb[0].d));
                chk("b_dout_oob", 32'(bus_b.dout_oob), 32'(qb[0].oob));
            end
            if (b_stall) chk("b_hold", 32'({bus_b.out_valid, bus_b.dout, bus_b.dout_oob}), 32'({1'b1, b_prev}));
        end
        a_stall = armed && !rst && bus_a.out_valid && !bus_a.out_ready;
        a_prev  = {bus_a.dout, bus_a.dout_oob};
        b_stall = armed && !rst && bus_b.out_valid && !bus_b.out_ready;
        b_prev  = {bus_b.dout, bus_b.dout_oob};
        if (rst) begin
            qa.delete();
            qb.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (bus_a.out_valid && bus_a.out_ready && qa.size() > 0) begin
                it = qa.pop_front();
                loga.push_back('{d: bus_a.dout, oob: bus_a.dout_oob, t: cyc - it.t, oc: cyc});
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                it   = ref_a(bus_a.din, bus_a.sel);
                it.t = cyc;
                qa.push_back(it);
            end
            if (bus_b.out_valid && bus_b.out_ready && qb.size() > 0) begin
                it = qb.pop_front();
                logb.push_back('{d: bus_b.dout, oob: bus_b.dout_oob, t: cyc - it.t, oc: cyc});
            end
            if (bus_b.in_valid && bus_b.in_ready) begin
                it   = ref_b(bus_b.din, bus_b.sel);
                it.t = cyc;
                qb.push_back(it);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan_a();
        for (int k = 0; k < 16; k++) bus_a.din[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    task automatic set_chan_b();
        for (int k = 0; k < 5; k++) bus_b.din[k*8 +: 8] = 8'(8'h60 + k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int ph;
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.sel = '0; bus_a.out_ready = 1'b1; set_chan_a();
        bus_b.in_valid = 1'b0; bus_b.sel = '0; bus_b.out_ready = 1'b1; set_chan_b();
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_a_dout", 32'(bus_a.dout), 32'h00);
        chk("rst_a_oob", 32'(bus_a.dout_oob), 32'd0);
        chk("rst_a_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(bus_b.out_valid), 32'd0);
        tick();

        // In-order sweep of every channel at full rate.
        loga.delete();
        for (int i = 0; i < 16; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.sel      = 5'(i);
            tick();
        end
        bus_a.in_valid = 1'b0;
        repeat (4) tick();
        chk("sweep_count", 32'(loga.size()), 32'd16);
        for (int i = 0; i < 16 && i < loga.size(); i++) begin
            chk("sweep_data", 32'(loga[i].d), 32'(8'h10 + i));
            chk("sweep_oob", 32'(loga[i].oob), 32'd0);
            chk("sweep_latency", 32'(loga[i].t), 32'd2);
        end

        // Out-of-range selects deliver channel 0 flagged.
        loga.delete();
        bus_a.din[7:0] = 8'hA5;
        bus_a.in_valid = 1'b1;
        bus_a.sel = 5'd16; tick();
        bus_a.sel = 5'd31; tick();
        bus_a.sel = 5'd3;  tick();
        bus_a.in_valid = 1'b0;
        repeat (4) tick();
        chk("oob_count", 32'(loga.size()), 32'd3);
        if (loga.size() == 3) begin
            chk("oob16_data", 32'(loga[0].d), 32'hA5);
            chk("oob16_flag", 32'(loga[0].oob), 32'd1);
            chk("oob31_data", 32'(loga[1].d), 32'hA5);
            chk("oob31_flag", 32'(loga[1].oob), 32'd1);
            chk("sel3_data", 32'(loga[2].d), 32'h13);
            chk("sel3_flag", 32'(loga[2].oob), 32'd0);
        end

        // Backpressure with toggling ready and random input gaps.
        set_chan_a();
        loga.delete();
        nxt = 0;
        ph  = 0;
        while (nxt < 8 && ph < 200) begin
            bus_a.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            bus_a.in_valid  = ($urandom_range(0, 2) != 0);
            bus_a.sel       = 5'(nxt);
            @(negedge clk);
            if (bus_a.in_valid && bus_a.in_ready) nxt++;
            tick();
            ph++;
        end
        chk("bp_stream_done", 32'(nxt), 32'd8);
        bus_a.in_valid = 1'b0;
        repeat (6) begin
            bus_a.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            tick();
            ph++;
        end
        bus_a.out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_count", 32'(loga.size()), 32'd8);
        for (int i = 0; i < 8 && i < loga.size(); i++) chk("bp_data", 32'(loga[i].d), 32'(8'h10 + i));

        // Bubble collapse: second item is accepted behind a stalled head.
        loga.delete();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.sel = 5'd1; tick();
        bus_a.in_valid = 1'b0; tick(); tick();
        bus_a.in_valid = 1'b1; bus_a.sel = 5'd2;
        @(negedge clk);
        chk("bubble_in_ready", 32'(bus_a.in_ready), 32'd1);
        tick();
        bus_a.in_valid = 1'b0;
        tick(); tick();
        bus_a.out_ready = 1'b1;
        repeat (4) tick();
        chk("bubble_count", 32'(loga.size()), 32'd2);
        if (loga.size() == 2) begin
            chk("bubble_first", 32'(loga[0].d), 32'h11);
            chk("bubble_second", 32'(loga[1].d), 32'h12);
            chk("bubble_b2b", 32'(loga[1].oc - loga[0].oc), 32'd1);
        end

        // Reset with two transfers in flight discards both.
        loga.delete();
        bus_a.in_valid = 1'b1; bus_a.sel = 5'd4; tick();
        bus_a.sel = 5'd5; tick();
        bus_a.in_valid = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("midrst_dout", 32'(bus_a.dout), 32'h00);
        chk("midrst_oob", 32'(bus_a.dout_oob), 32'd0);
        tick();
        repeat (5) tick();
        chk("midrst_no_stale", 32'(loga.size()), 32'd0);

        // Random soak on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            bus_a.din       = {$urandom, $urandom, $urandom, $urandom};
            bus_a.sel       = 5'($urandom);
            bus_a.in_valid  = ($urandom_range(0, 3) != 0);
            bus_a.out_ready = ($urandom_range(0, 9) < 7);
            bus_b.din       = 40'({$urandom, $urandom});
            bus_b.sel       = 3'($urandom);
            bus_b.in_valid  = ($urandom_range(0, 3) != 0);
            bus_b.out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        repeat (5) tick();
        chk("soak_a_drained", 32'(qa.size()), 32'd0);
        chk("soak_b_drained", 32'(qb.size()), 32'd0);

        // Five-input instance: partial group and clamped selects.
        set_chan_b();
        logb.delete();
        bus_b.in_valid = 1'b1;
        for (int s = 4; s < 8; s++) begin
            bus_b.sel = 3'(s);
            tick();
        end
        bus_b.in_valid = 1'b0;
        repeat (4) tick();
        chk("b_count", 32'(logb.size()), 32'd4);
        if (logb.size() == 4) begin
            chk("b_sel4_data", 32'(logb[0].d), 32'h64);
            chk("b_sel4_oob", 32'(logb[0].oob), 32'd0);
            chk("b_sel4_latency", 32'(logb[0].t), 32'd2);
            for (int i = 1; i < 4; i++) begin
                chk("b_oob_data", 32'(logb[i].d), 32'h60);
                chk("b_oob_flag", 32'(logb[i].oob), 32'd1);
                chk("b_oob_latency", 32'(logb[i].t), 32'd2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
